imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//   Writer-side counterpart of the instruction memory: receives a program as a
//   byte stream and writes it into instruction memory as 32-bit words at
//   byte addresses 0,4,8,... (the same stride the PC adder uses).
//   Holds the pipeline via cpu_hold while loading, then releases it with a done pulse.
//   Sits between a byte source (UART/bench) and the instruction memory write port.
// PARAMETERS
//   ADDR_W     9    instruction memory byte-address width (matches PC width)
//   MEM_WORDS  128  words actually writable; 4*MEM_WORDS <= 2**ADDR_W
// PORTS
//   clk         in   1       clock, all state on rising edge
//   reset       in   1       synchronous, active-high reset
//   start       in   1       begin a load; sampled only in IDLE
//   rx_valid    in   1       source has a byte on rx_data
//   rx_data     in   8       stream byte
//   rx_ready    out  1       loader accepts byte this cycle (combinational from state)
//   imem_we     out  1       instruction memory write strobe, one cycle per word
//   imem_addr   out  ADDR_W  byte address of word being written (multiple of 4)
//   imem_wdata  out  32      word being written
//   cpu_hold    out  1       pipeline must hold PC in reset while high
//   done        out  1       one-cycle pulse: load finished
//   err         out  1       sticky: header word count exceeded MEM_WORDS
// BEHAVIOUR
// - Byte accepted only when rx_valid && rx_ready; source holds data otherwise.
// - Stream format: 1 header byte = word count N (0..255), then 4*N bytes,
//   each word big-endian (first byte -> wdata[31:24]).
// - Reset: state IDLE; rx_ready, imem_we, cpu_hold, done, err = 0;
//   imem_addr = 0, imem_wdata = 0; word/byte counters = 0; partial word discarded.
// - States:
//   IDLE : rx_ready=0. start=1 -> HDR; err cleared, addr/counters zeroed.
//   HDR  : rx_ready=1, cpu_hold=1. On accept: N=rx_data; N==0 -> DONE;
//          N>MEM_WORDS -> err=1 (sticky until next start); else -> BYTE.
//   BYTE : rx_ready=1, cpu_hold=1. Shift bytes into word; after 4th accept -> WRITE.
//   WRITE: rx_ready=0, cpu_hold=1. imem_we=1 exactly this cycle with imem_addr and
//          imem_wdata stable, unless word index >= MEM_WORDS (strobe suppressed,
//          bytes still consumed). Then addr += 4, remaining -= 1;
//          remaining==0 -> DONE else -> BYTE.
//   DONE : done=1 for this one cycle, cpu_hold=0, rx_ready=0; -> IDLE.
// - cpu_hold asserts the cycle after start is sampled, deasserts in DONE.
// - Latency: WRITE is the cycle immediately after the 4th byte of a word is accepted;
//   max throughput 4 bytes per 5 cycles.
// - start outside IDLE is ignored; start and reset together: reset wins.
// - imem_wdata holds last written word after WRITE; imem_addr holds next address.
// - Address never wraps: suppressed writes beyond MEM_WORDS do not modify addr.
// - Reset mid-load: abort immediately, no write of partial word, all outputs
//   return to reset values next cycle; a new start performs a clean load.
// TESTING
//   1 start; N=1, bytes 00 22 18 20 -> one write addr 0x000 data 0x00221820,
//     done pulse next cycle, cpu_hold high from cycle after start until DONE.
//   2 N=5, five MIPS words with random rx_valid gaps -> writes at 0,4,8,12,16
//     in order, exact data, no byte dropped or duplicated, rx_ready=0 in WRITE.
//   3 N=0 -> no imem_we, done pulse one cycle after header accept, err=0.
//   4 N=130, 520 bytes -> 128 writes, last at 0x1FC; err=1; done after byte 520;
//     err clears on next start.
//   5 reset after 2 bytes of word 0 -> no imem_we, outputs at reset values;
//     following N=1 load writes addr 0 correctly.
//   6 start pulsed during BYTE/WRITE -> ignored, load completes unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: header byte N, then N big-endian words written to
// instruction memory at byte addresses 0,4,8,... while the CPU is held.
module imem_loader #(
    parameter int ADDR_W    = 9,
    parameter int MEM_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BYTE,
        WRITE,
        DONE
    } state_t;

    localparam logic [8:0] MaxWords = 9'(MEM_WORDS);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [23:0]       shift_q;
    logic [1:0]        byteCnt_q;
    logic [7:0]        remaining_q;
    logic [7:0]        wordIdx_q;
    logic              we_q;
    logic              hold_q;
    logic              done_q;
    logic              err_q;

    logic        accept;
    logic        inRange;
    logic        lastSlot;
    logic [31:0] word_d;

    assign rx_ready = (state_q == HDR) || (state_q == BYTE);
    assign accept   = rx_valid && rx_ready;
    assign word_d   = {shift_q, rx_data};
    assign inRange  = {1'b0, wordIdx_q} < MaxWords;
    assign lastSlot = {1'b0, wordIdx_q} == (MaxWords - 9'd1);

    // The address stops at the last writable word instead of stepping past the
    // top of memory, so it can never wrap back onto word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            shift_q     <= '0;
            byteCnt_q   <= '0;
            remaining_q <= '0;
            wordIdx_q   <= '0;
            we_q        <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= HDR;
                        hold_q      <= 1'b1;
                        err_q       <= 1'b0;
                        addr_q      <= '0;
                        byteCnt_q   <= '0;
                        wordIdx_q   <= '0;
                        remaining_q <= '0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        remaining_q <= rx_data;
                        if (rx_data == 8'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            if ({1'b0, rx_data} > MaxWords) begin
                                err_q <= 1'b1;
                            end
                            state_q <= BYTE;
                        end
                    end
                end
                BYTE: begin
                    if (accept) begin
                        shift_q   <= word_d[23:0];
                        byteCnt_q <= byteCnt_q + 2'd1;
                        if (byteCnt_q == 2'd3) begin
                            state_q <= WRITE;
                            if (inRange) begin
                                we_q    <= 1'b1;
                                wdata_q <= word_d;
                            end
                        end
                    end
                end
                WRITE: begin
                    wordIdx_q   <= wordIdx_q + 8'd1;
                    remaining_q <= remaining_q - 8'd1;
                    if (inRange && !lastSlot) begin
                        addr_q <= addr_q + ADDR_W'(4);
                    end
                    if (remaining_q == 8'd1) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                    end else begin
                        state_q <= BYTE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
